johnson_ring_ctr_gen: RTL

//  Parametrised twisted-ring / one-hot ring phase counter; the next generation of the

---
 rtl/johnson_ctr_pkg.sv | 10 +
 rtl/ctr_state_decode.sv | 31 +++
 rtl/johnson_ring_ctr_gen.sv | 55 +++++
 3 files changed

// File: rtl/johnson_ctr_pkg.sv
// johnson_ctr_pkg: shared mode enum and sizing helpers for the phase counter
package johnson_ctr_pkg;
  typedef enum logic {MODE_JOHNSON = 1'b0, MODE_RING = 1'b1} ctr_mode_e;
  function automatic int ph_w(input int width);
    return $clog2(2 * width);
  endfunction
  function automatic logic [63:0] reset_val(input int width, input ctr_mode_e mode);
    return (mode == MODE_RING && width > 0) ? 64'd1 : 64'd0;
  endfunction
endpackage

// File: rtl/ctr_state_decode.sv
// ctr_state_decode: combinational phase index and illegal-state flag from the counter state
module ctr_state_decode
  import johnson_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE = 0,
  localparam int PH_W = ph_w(WIDTH)
)(
  input  logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             err
);
  localparam int PW = PH_W + 1;
  localparam ctr_mode_e M = (MODE != 0) ? MODE_RING : MODE_JOHNSON;
  logic [PW-1:0]   pop;
  logic [PW-1:0]   tr;
  logic [PH_W-1:0] idx;
  // popcount, neighbour transitions and set-bit index feed both legality and phase
  always_comb begin
    pop = '0;
    tr = '0;
    idx = '0;
    for (int k = 0; k < WIDTH; k++) pop = pop + PW'(q[k]);
    for (int k = 0; k < WIDTH - 1; k++) tr = tr + PW'(q[k] ^ q[k+1]);
    for (int k = 0; k < WIDTH; k++) idx = q[k] ? PH_W'(k) : idx;
    err = (M == MODE_RING) ? (pop != PW'(1)) : (tr > PW'(1));
    phase = err ? '0 :
            (M == MODE_RING) ? idx :
            q[WIDTH-1] ? PH_W'(PW'(2 * WIDTH) - pop) : PH_W'(pop);
  end
endmodule

// File: rtl/johnson_ring_ctr_gen.sv
// johnson_ring_ctr_gen: parametrised Johnson / one-hot ring phase counter with wrap pulse
module johnson_ring_ctr_gen
  import johnson_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE = 0,
  parameter int SELF_CORRECT = 1,
  localparam int PH_W = ph_w(WIDTH)
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_wrap,
  output logic             o_err
);
  localparam ctr_mode_e M = (MODE != 0) ? MODE_RING : MODE_JOHNSON;
  localparam logic [WIDTH-1:0] RV = WIDTH'(reset_val(WIDTH, M));
  localparam logic [PH_W-1:0] LAST = PH_W'((M == MODE_RING) ? WIDTH - 1 : 2 * WIDTH - 1);
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;
  logic             fix;
  logic             step;
  logic             wrap_nxt;
  ctr_state_decode #(.WIDTH(WIDTH), .MODE(MODE)) u_dec (
    .q     (o_q),
    .phase (o_phase),
    .err   (o_err)
  );
  // prioritised next state; wrap only on a genuine step across the phase-0 boundary
  always_comb begin
    q_step = (M == MODE_RING) ?
             (i_dir ? {o_q[0], o_q[WIDTH-1:1]} : {o_q[WIDTH-2:0], o_q[WIDTH-1]}) :
             (i_dir ? {~o_q[0], o_q[WIDTH-1:1]} : {o_q[WIDTH-2:0], ~o_q[WIDTH-1]});
    fix = o_err && (SELF_CORRECT != 0);
    step = !i_clr && !i_load && !fix && i_en;
    q_nxt = i_clr ? RV : i_load ? i_load_val : fix ? RV : i_en ? q_step : o_q;
    wrap_nxt = step && !o_err && (i_dir ? (o_phase == '0) : (o_phase == LAST));
  end
  // state register and wrap pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RV;
      o_wrap <= 1'b0;
    end else begin
      o_q <= q_nxt;
      o_wrap <= wrap_nxt;
    end
  end
endmodule
